// File: rtl/huffman_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : huffman_pkg
//  Purpose  : Shared constants and state encoding for the Huffman packer.
//  Revision : 1.0  initial release
// ============================================================================
package huffman_pkg;

    localparam int NSYM         = 6;           // symbol values 1..NSYM
    localparam int CODE_W       = 8;           // width of HCn / Mn
    localparam int MAX_CODE_LEN = CODE_W - 1;  // longest legal code
    localparam int BYTE_W       = 8;           // output byte width
    localparam int ACC_W        = 15;          // >= 2*MAX_CODE_LEN+1
    localparam int CNT_W        = 4;           // holds 0..14 valid bits

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/huffman_len_decode.sv
`default_nettype none
// ============================================================================
//  Module   : huffman_len_decode
//  Purpose  : Mask -> code length (population count of an 8-bit mask).
//  Revision : 1.0  initial release
// ============================================================================
module huffman_len_decode
    import huffman_pkg::*;
(
    input  logic [CODE_W-1:0] mask_i,
    output logic [CNT_W-1:0]  len_o
);

    // Count the set bits of the mask
    always_comb begin
        len_o = '0;
        for (int i = 0; i < CODE_W; i++) begin
            len_o = len_o + CNT_W'(mask_i[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/huffman_packer.sv
`default_nettype none
// ============================================================================
//  Module   : huffman_packer
//  Purpose  : Latches a six-entry Huffman table, encodes symbols 1..6 and
//             packs the codes MSB-first into a valid/ready byte stream, with
//             zero padding of the final byte at end of stream.
//  Options  : HUFF_PACKER_BITCNT_EN adds a saturating bit_count output.
//  Revision : 1.0  initial release
// ============================================================================
module huffman_packer
    import huffman_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] HC1,
    input  logic [CODE_W-1:0] HC2,
    input  logic [CODE_W-1:0] HC3,
    input  logic [CODE_W-1:0] HC4,
    input  logic [CODE_W-1:0] HC5,
    input  logic [CODE_W-1:0] HC6,
    input  logic [CODE_W-1:0] M1,
    input  logic [CODE_W-1:0] M2,
    input  logic [CODE_W-1:0] M3,
    input  logic [CODE_W-1:0] M4,
    input  logic [CODE_W-1:0] M5,
    input  logic [CODE_W-1:0] M6,
    input  logic              sym_valid,
    input  logic [BYTE_W-1:0] sym_data,
    input  logic              sym_last,
    output logic              sym_ready,
    output logic              out_valid,
    output logic [BYTE_W-1:0] out_data,
    input  logic              out_ready,
    output logic              done,
    output logic              err_sym
`ifdef HUFF_PACKER_BITCNT_EN
    ,
    output logic [15:0]       bit_count
`endif
);

    logic [CODE_W-1:0] w_hc_in  [NSYM];
    logic [CODE_W-1:0] w_m_in   [NSYM];
    logic [CNT_W-1:0]  w_len_in [NSYM];

    logic [CODE_W-1:0] hc_q  [NSYM];
    logic [CNT_W-1:0]  len_q [NSYM];

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [BYTE_W-1:0] out_data_q, out_data_d;
    logic              err_q, err_d;

    logic              w_load;
    logic              w_sym_fire;
    logic              w_out_fire;
    logic              w_sym_ok;
    logic [CODE_W-1:0] w_sel_hc;
    logic [CNT_W-1:0]  w_sel_len;
    logic [CNT_W-1:0]  w_shamt;
    logic [ACC_W-1:0]  w_ins;
    logic              w_has_byte;
    logic              w_has_tail;

    assign w_hc_in[0] = HC1;  assign w_m_in[0] = M1;
    assign w_hc_in[1] = HC2;  assign w_m_in[1] = M2;
    assign w_hc_in[2] = HC3;  assign w_m_in[2] = M3;
    assign w_hc_in[3] = HC4;  assign w_m_in[3] = M4;
    assign w_hc_in[4] = HC5;  assign w_m_in[4] = M5;
    assign w_hc_in[5] = HC6;  assign w_m_in[5] = M6;

    generate
        for (genvar g = 0; g < NSYM; g++) begin : g_len
            huffman_len_decode u_len (
                .mask_i (w_m_in[g]),
                .len_o  (w_len_in[g])
            );
        end
    endgenerate

    assign w_load     = (state_q == ST_IDLE) && code_valid;
    assign sym_ready  = (state_q == ST_RUN) && (cnt_q < CNT_W'(BYTE_W));
    assign w_sym_fire = sym_valid && sym_ready;
    assign w_out_fire = out_valid_q && out_ready;
    assign w_has_byte = cnt_q >= CNT_W'(BYTE_W);
    assign w_has_tail = (cnt_q != '0) && !w_has_byte;

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign done       = (state_q == ST_DONE);
    assign err_sym    = err_q;

    // Look up the offered symbol in the latched table
    always_comb begin
        w_sym_ok  = 1'b0;
        w_sel_hc  = '0;
        w_sel_len = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (sym_data == BYTE_W'(i + 1)) begin
                w_sym_ok  = 1'b1;
                w_sel_hc  = hc_q[i];
                w_sel_len = len_q[i];
            end
        end
    end

    // Left-aligned insert position; cnt < 8 and len <= 8 keep this >= 0
    assign w_shamt = CNT_W'(ACC_W) - cnt_q - w_sel_len;
    assign w_ins   = ACC_W'(w_sel_hc) << w_shamt;

    // Table registers, written only on a load from IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSYM; i++) begin
                hc_q[i]  <= '0;
                len_q[i] <= '0;
            end
        end else if (w_load) begin
            for (int i = 0; i < NSYM; i++) begin
                hc_q[i]  <= w_hc_in[i];
                len_q[i] <= w_len_in[i];
            end
        end
    end

    // Next-state, accumulator and output-byte logic
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (code_valid) begin
                    state_d = ST_RUN;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (w_sym_fire) begin
                    if (!w_sym_ok) begin
                        err_d = 1'b1;
                    end else if (w_sel_len != '0) begin
                        acc_d = acc_q | w_ins;
                        cnt_d = cnt_q + w_sel_len;
                    end
                    if (sym_last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (!out_valid_q && (cnt_q == '0)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A byte is never offered while a symbol is accepted: an offered
        // byte implies cnt >= 8, which already holds sym_ready low.
        if (w_out_fire) begin
            acc_d       = acc_q << BYTE_W;
            cnt_d       = w_has_byte ? (cnt_q - CNT_W'(BYTE_W)) : '0;
            out_valid_d = 1'b0;
        end else if (!out_valid_q &&
                     (((state_q == ST_RUN || state_q == ST_FLUSH) && w_has_byte) ||
                      ((state_q == ST_FLUSH) && w_has_tail))) begin
            // Bits below cnt are always zero, so the tail byte is pre-padded
            out_valid_d = 1'b1;
            out_data_d  = acc_q[ACC_W-1 -: BYTE_W];
        end
    end

    // State, accumulator and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

`ifdef HUFF_PACKER_BITCNT_EN
    logic [15:0] bitcnt_q, bitcnt_d;
    logic [16:0] w_bc_sum;

    assign w_bc_sum  = {1'b0, bitcnt_q} + 17'(w_sel_len);
    assign bit_count = bitcnt_q;

    // Saturating count of code bits appended since the last table load
    always_comb begin
        bitcnt_d = bitcnt_q;
        if (w_load) begin
            bitcnt_d = '0;
        end else if (w_sym_fire && w_sym_ok) begin
            bitcnt_d = w_bc_sum[16] ? 16'hFFFF : w_bc_sum[15:0];
        end
    end

    // Bit counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitcnt_q <= '0;
        end else begin
            bitcnt_q <= bitcnt_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_huffman_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_huffman_packer
//  Purpose  : Scoreboard bench for huffman_packer; a bit-queue model pushes
//             expected bytes as symbols are accepted.
//  Options  : HUFF_PACKER_BITCNT_EN also checks bit_count.
//  Revision : 1.0  initial release
// ============================================================================
module tb_huffman_packer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       code_valid = 1'b0;
    logic [7:0] hc [1:6];
    logic [7:0] mk [1:6];
    logic       sym_valid = 1'b0;
    logic [7:0] sym_data = '0;
    logic       sym_last = 1'b0;
    logic       sym_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic       done;
    logic       err_sym;
`ifdef HUFF_PACKER_BITCNT_EN
    logic [15:0] bit_count;
`endif

    huffman_packer dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .HC1 (hc[1]), .HC2 (hc[2]), .HC3 (hc[3]),
        .HC4 (hc[4]), .HC5 (hc[5]), .HC6 (hc[6]),
        .M1  (mk[1]), .M2  (mk[2]), .M3  (mk[3]),
        .M4  (mk[4]), .M5  (mk[5]), .M6  (mk[6]),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_last   (sym_last),
        .sym_ready  (sym_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .done       (done),
        .err_sym    (err_sym)
`ifdef HUFF_PACKER_BITCNT_EN
        ,
        .bit_count  (bit_count)
`endif
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] sb [$];
    bit         mbits [$];
    logic [7:0] m_code [1:6];
    int         m_len  [1:6];
    int         exp_bits = 0;
    bit         exp_err = 1'b0;
    int         rdy_mode = 1;
    int         rx_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] last_rx = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output consumer: 0 = stalled, 1 = always ready, other = random
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Byte monitor: compare each handshaken byte with the scoreboard
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            chk("sb_has_entry", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) chk("byte", out_data, sb.pop_front());
            rx_cnt++;
            last_rx = out_data;
        end
        if (done) done_cnt++;
    end

    task automatic model_sym(input int s, input bit last);
        logic [7:0] by;
        if (s >= 1 && s <= 6) begin
            for (int b = m_len[s] - 1; b >= 0; b--) mbits.push_back(m_code[s][b]);
            exp_bits += m_len[s];
        end else begin
            exp_err = 1'b1;
        end
        while (mbits.size() >= 8) begin
            by = '0;
            for (int k = 0; k < 8; k++) by = {by[6:0], mbits.pop_front()};
            sb.push_back(by);
        end
        if (last && mbits.size() > 0) begin
            by = '0;
            for (int k = 0; k < 8; k++) by = {by[6:0], (mbits.size() > 0) ? mbits.pop_front() : 1'b0};
            sb.push_back(by);
        end
    endtask

    task automatic load_table();
        @(posedge clk); #1;
        code_valid = 1'b1;
        @(posedge clk); #1;
        code_valid = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            m_code[i] = hc[i];
            m_len[i]  = $countones(mk[i]);
        end
        mbits.delete();
        exp_bits = 0;
        exp_err  = 1'b0;
        chk("err_cleared_on_load", err_sym, 0);
`ifdef HUFF_PACKER_BITCNT_EN
        chk("bit_count_cleared", bit_count, 0);
`endif
    endtask

    task automatic send_sym(input int s, input bit last);
        bit ok = 1'b0;
        sym_valid = 1'b1;
        sym_data  = 8'(s);
        sym_last  = last;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sym_ready) begin ok = 1'b1; break; end
        end
        chk("sym_accepted", 32'(ok), 1);
        if (ok) begin
            @(posedge clk); #1;
            model_sym(s, last);
        end
        sym_valid = 1'b0;
        sym_last  = 1'b0;
    endtask

    task automatic run_tail(input string tag);
        bit got = 1'b0;
        int d0 = done_cnt;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin got = 1'b1; break; end
        end
        chk({tag, "_done_seen"}, 32'(got), 1);
        repeat (3) @(negedge clk);
        chk({tag, "_done_once"}, 32'(done_cnt - d0), 1);
        chk({tag, "_sb_drained"}, 32'(sb.size()), 0);
        chk({tag, "_err_sym"}, err_sym, exp_err);
`ifdef HUFF_PACKER_BITCNT_EN
        chk({tag, "_bit_count"}, bit_count, exp_bits);
`endif
    endtask

    task automatic run_stream(input int syms[$], input string tag);
        foreach (syms[i]) send_sym(syms[i], i == syms.size() - 1);
        run_tail(tag);
    endtask

    task automatic set_table1();
        hc[1] = 8'd1; hc[2] = 8'd0; hc[3] = 8'd1;
        hc[4] = 8'd3; hc[5] = 8'd5; hc[6] = 8'd7;
        mk[1] = 8'd1; mk[2] = 8'd1; mk[3] = 8'd3;
        mk[4] = 8'd7; mk[5] = 8'd7; mk[6] = 8'd7;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s[$];
        int rx0;
        int d0;
        int n;
        int l;
        set_table1();

        // Reset values
        #12;
        chk("rst_sym_ready", sym_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err_sym", err_sym, 0);
`ifdef HUFF_PACKER_BITCNT_EN
        chk("rst_bit_count", bit_count, 0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic stream
        rdy_mode = 1;
        load_table();
        s = {1, 2, 3, 3, 2};
        run_stream(s, "basic");

        // Eight one-bit codes fill exactly one byte
        load_table();
        rx0 = rx_cnt;
        s = {1, 1, 1, 1, 1, 1, 1, 1};
        run_stream(s, "eight_ones");
        chk("eight_ones_nbytes", 32'(rx_cnt - rx0), 1);
        chk("eight_ones_value", last_rx, 8'hFF);

        // Backpressure with seven-bit codes
        rdy_mode = 0;
        hc[1] = 8'h55; hc[2] = 8'h2A; hc[3] = 8'h7F;
        hc[4] = 8'h01; hc[5] = 8'h40; hc[6] = 8'h33;
        for (int i = 1; i <= 6; i++) mk[i] = 8'h7F;
        load_table();
        send_sym(1, 1'b0);
        send_sym(2, 1'b0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("bp_sym_ready_low", sym_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data_hold", out_data, sb.size() > 0 ? sb[0] : 8'hxx);
            @(negedge clk);
        end
        rdy_mode = 1;
        s = {3, 4, 5, 6};
        run_stream(s, "backpressure");

        // Invalid symbols mid-stream
        set_table1();
        load_table();
        s = {1, 0, 3, 7, 2, 4, 5, 6};
        run_stream(s, "invalid");

        // Reset with five bits pending
        load_table();
        send_sym(4, 1'b0);
        send_sym(3, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sym_ready", sym_ready, 0);
        sb.delete();
        mbits.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rx0 = rx_cnt;
        d0  = done_cnt;
        repeat (20) @(negedge clk);
        chk("midrst_no_bytes", 32'(rx_cnt - rx0), 0);
        chk("midrst_no_done", 32'(done_cnt - d0), 0);
        load_table();
        s = {1, 2, 3, 3, 2};
        run_stream(s, "after_reset");

        // Random tables and streams with random output backpressure
        rdy_mode = 2;
        for (int t = 0; t < 4; t++) begin
            for (int i = 1; i <= 6; i++) begin
                l     = $urandom_range(0, 7);
                mk[i] = 8'((1 << l) - 1);
                hc[i] = 8'($urandom) & mk[i];
            end
            load_table();
            n = $urandom_range(1, 200);
            s.delete();
            for (int k = 0; k < n; k++) s.push_back($urandom_range(1, 6));
            run_stream(s, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
